// File: rtl/hedios_register_bank.sv
// hedios_register_bank: COUNT x DEPTH register bank with HEDIOS and user write ports,
// registered read port and same-address race tracking. Optional counter: HEDIOS_REG_RACE_COUNTER_EN.
module hedios_reg_cell #(
    parameter int DEPTH         = 8,
    parameter int USER_PRIORITY = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             h_hit,
    input  logic             u_hit,
    input  logic [DEPTH-1:0] hedios_in,
    input  logic [DEPTH-1:0] user_in,
    output logic [DEPTH-1:0] q
);
    always_ff @(posedge clk) begin
        if (rst)
            q <= '0;
        else if (h_hit && u_hit)
            q <= (USER_PRIORITY != 0) ? user_in : hedios_in;
        else if (h_hit)
            q <= hedios_in;
        else if (u_hit)
            q <= user_in;
    end
endmodule

module hedios_register_bank #(
    parameter int DEPTH         = 8,
    parameter int COUNT         = 8,
    parameter int ADDR_W        = 3,
    parameter int USER_PRIORITY = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] hedios_addr,
    input  logic [DEPTH-1:0]  hedios_in,
    input  logic              hedios_we,
    input  logic [ADDR_W-1:0] user_addr,
    input  logic [DEPTH-1:0]  user_in,
    input  logic              user_we,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DEPTH-1:0]  rd_data,
    output logic              race_condition,
    output logic [ADDR_W-1:0] race_addr,
    output logic [COUNT-1:0]  race_sticky,
    input  logic              race_clear,
    output logic [7:0]        race_count
);
    logic [COUNT-1:0][DEPTH-1:0] regs;
    logic h_ok, rd_ok, race;

    assign h_ok  = 32'(hedios_addr) < COUNT;
    assign rd_ok = 32'(rd_addr) < COUNT;
    // Out-of-range addresses never match a cell, so such writes drop out; the race needs h_ok too.
    assign race  = hedios_we && user_we && h_ok && (hedios_addr == user_addr);

    genvar i;
    generate
        for (i = 0; i < COUNT; i++) begin : g_reg
            hedios_reg_cell #(
                .DEPTH         (DEPTH),
                .USER_PRIORITY (USER_PRIORITY)
            ) u_cell (
                .clk       (clk),
                .rst       (rst),
                .h_hit     (hedios_we && (hedios_addr == ADDR_W'(i))),
                .u_hit     (user_we && (user_addr == ADDR_W'(i))),
                .hedios_in (hedios_in),
                .user_in   (user_in),
                .q         (regs[i])
            );
        end
    endgenerate

    // Read samples the pre-write contents of the addressed register.
    always_ff @(posedge clk) begin
        if (rst)
            rd_data <= '0;
        else
            rd_data <= rd_ok ? regs[rd_addr] : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            race_condition <= 1'b0;
            race_addr      <= '0;
            race_sticky    <= '0;
        end else begin
            race_condition <= race;
            if (race)
                race_addr <= hedios_addr;
            // A new race on a bit beats a simultaneous clear of that bit.
            for (int k = 0; k < COUNT; k++) begin
                if (race && (hedios_addr == ADDR_W'(k)))
                    race_sticky[k] <= 1'b1;
                else if (race_clear)
                    race_sticky[k] <= 1'b0;
            end
        end
    end

`ifdef HEDIOS_REG_RACE_COUNTER_EN
    logic [7:0] cnt;
    always_ff @(posedge clk) begin
        if (rst)
            cnt <= 8'd0;
        else if (race_clear)
            cnt <= race ? 8'd1 : 8'd0;
        else if (race && (cnt != 8'hFF))
            cnt <= cnt + 8'd1;
    end
    assign race_count = cnt;
`else
    assign race_count = 8'd0;
`endif
endmodule

// File: tb/tb_hedios_register_bank.sv
// Scoreboard bench for hedios_register_bank: one DUT per USER_PRIORITY setting, shared stimulus.
module tb_hedios_register_bank;
    localparam int DEPTH = 8, COUNT = 8, ADDR_W = 3;

    logic clk = 1'b0;
    logic rst;
    logic [ADDR_W-1:0] hedios_addr, user_addr, rd_addr;
    logic [DEPTH-1:0]  hedios_in, user_in;
    logic hedios_we, user_we, race_clear;

    logic [DEPTH-1:0]  rd_u, rd_h;
    logic              rc_u, rc_h;
    logic [ADDR_W-1:0] ra_u, ra_h;
    logic [COUNT-1:0]  st_u, st_h;
    logic [7:0]        cnt_u, cnt_h;

    always #5 clk = ~clk;

    hedios_register_bank #(.DEPTH(DEPTH), .COUNT(COUNT), .ADDR_W(ADDR_W), .USER_PRIORITY(1)) dut_u (
        .clk(clk), .rst(rst), .hedios_addr(hedios_addr), .hedios_in(hedios_in), .hedios_we(hedios_we),
        .user_addr(user_addr), .user_in(user_in), .user_we(user_we), .rd_addr(rd_addr), .rd_data(rd_u),
        .race_condition(rc_u), .race_addr(ra_u), .race_sticky(st_u), .race_clear(race_clear),
        .race_count(cnt_u));

    hedios_register_bank #(.DEPTH(DEPTH), .COUNT(COUNT), .ADDR_W(ADDR_W), .USER_PRIORITY(0)) dut_h (
        .clk(clk), .rst(rst), .hedios_addr(hedios_addr), .hedios_in(hedios_in), .hedios_we(hedios_we),
        .user_addr(user_addr), .user_in(user_in), .user_we(user_we), .rd_addr(rd_addr), .rd_data(rd_h),
        .race_condition(rc_h), .race_addr(ra_h), .race_sticky(st_h), .race_clear(race_clear),
        .race_count(cnt_h));

    typedef struct {
        logic [DEPTH-1:0]  rd_u;
        logic [DEPTH-1:0]  rd_h;
        logic              rc;
        logic [ADDR_W-1:0] ra;
        logic [COUNT-1:0]  st;
        logic [7:0]        cnt;
    } exp_t;

    exp_t exp_q[$];
    int checks = 0;
    int errors = 0;

    logic [DEPTH-1:0]  mem_u [COUNT];
    logic [DEPTH-1:0]  mem_h [COUNT];
    logic [ADDR_W-1:0] m_ra;
    logic [COUNT-1:0]  m_st;
    logic [7:0]        m_cnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Drive one cycle, predict the post-edge outputs, then compare after the edge.
    task automatic cyc(input logic r, input logic hwe, input logic [ADDR_W-1:0] ha, input logic [DEPTH-1:0] hd,
                       input logic uwe, input logic [ADDR_W-1:0] ua, input logic [DEPTH-1:0] ud,
                       input logic [ADDR_W-1:0] ra, input logic clr);
        exp_t e;
        exp_t got;
        logic race;
        @(negedge clk);
        rst = r; hedios_we = hwe; hedios_addr = ha; hedios_in = hd;
        user_we = uwe; user_addr = ua; user_in = ud; rd_addr = ra; race_clear = clr;

        race = hwe && uwe && (ha == ua) && (int'(ha) < COUNT);
        if (r) begin
            for (int k = 0; k < COUNT; k++) begin mem_u[k] = '0; mem_h[k] = '0; end
            m_ra = '0; m_st = '0; m_cnt = 8'd0;
            e.rd_u = '0; e.rd_h = '0; e.rc = 1'b0;
        end else begin
            e.rd_u = (int'(ra) < COUNT) ? mem_u[ra] : '0;
            e.rd_h = (int'(ra) < COUNT) ? mem_h[ra] : '0;
            e.rc = race;
            // Apply the losing port first so the winner overwrites it on a race.
            if (hwe && int'(ha) < COUNT) mem_u[ha] = hd;
            if (uwe && int'(ua) < COUNT) mem_u[ua] = ud;
            if (uwe && int'(ua) < COUNT) mem_h[ua] = ud;
            if (hwe && int'(ha) < COUNT) mem_h[ha] = hd;
            if (race) m_ra = ha;
            if (clr) m_st = '0;
            if (race) m_st[ha] = 1'b1;
`ifdef HEDIOS_REG_RACE_COUNTER_EN
            if (clr) m_cnt = race ? 8'd1 : 8'd0;
            else if (race && m_cnt != 8'd255) m_cnt = m_cnt + 8'd1;
`else
            m_cnt = 8'd0;
`endif
        end
        e.ra = m_ra; e.st = m_st; e.cnt = m_cnt;
        exp_q.push_back(e);

        @(posedge clk);
        #1;
        got = exp_q.pop_front();
        chk("rd_data_user_prio",   32'(rd_u),  32'(got.rd_u));
        chk("rd_data_hedios_prio", 32'(rd_h),  32'(got.rd_h));
        chk("race_condition_u",    32'(rc_u),  32'(got.rc));
        chk("race_condition_h",    32'(rc_h),  32'(got.rc));
        chk("race_addr",           32'(ra_u),  32'(got.ra));
        chk("race_sticky_u",       32'(st_u),  32'(got.st));
        chk("race_sticky_h",       32'(st_h),  32'(got.st));
        chk("race_count_u",        32'(cnt_u), 32'(got.cnt));
        chk("race_count_h",        32'(cnt_h), 32'(got.cnt));
    endtask

    initial begin
        rst = 1'b1; hedios_we = 1'b0; user_we = 1'b0; race_clear = 1'b0;
        hedios_addr = '0; user_addr = '0; rd_addr = '0; hedios_in = '0; user_in = '0;
        m_ra = '0; m_st = '0; m_cnt = 8'd0;

        // Reset and sweep all addresses.
        cyc(1, 0, 0, 8'h00, 0, 0, 8'h00, 0, 0);
        cyc(1, 0, 0, 8'h00, 0, 0, 8'h00, 0, 0);
        for (int a = 0; a < COUNT; a++) cyc(0, 0, 0, 8'h00, 0, 0, 8'h00, ADDR_W'(a), 0);

        // Single-port writes, then read-before-write and 2-edge latency.
        cyc(0, 1, 3'd2, 8'hA5, 0, 0, 8'h00, 3'd2, 0);
        cyc(0, 0, 0, 8'h00, 1, 3'd5, 8'h3C, 3'd2, 0);
        cyc(0, 0, 0, 8'h00, 0, 0, 8'h00, 3'd5, 0);
        cyc(0, 0, 0, 8'h00, 0, 0, 8'h00, 3'd2, 0);

        // Dual write to different addresses is not a race.
        cyc(0, 1, 3'd1, 8'h11, 1, 3'd6, 8'h22, 3'd1, 0);
        cyc(0, 0, 0, 8'h00, 0, 0, 8'h00, 3'd1, 0);
        cyc(0, 0, 0, 8'h00, 0, 0, 8'h00, 3'd6, 0);

        // Race on addr 3: the two DUTs disagree on the winner.
        cyc(0, 1, 3'd3, 8'hAA, 1, 3'd3, 8'h55, 3'd3, 0);
        cyc(0, 0, 0, 8'h00, 0, 0, 8'h00, 3'd3, 0);
        cyc(0, 0, 0, 8'h00, 0, 0, 8'h00, 3'd3, 0);

        // Clear together with a race on addr 4: only bit 4 survives.
        cyc(0, 1, 3'd4, 8'h0F, 1, 3'd4, 8'hF0, 3'd4, 1);
        cyc(0, 0, 0, 8'h00, 0, 0, 8'h00, 3'd4, 0);
        cyc(0, 0, 0, 8'h00, 0, 0, 8'h00, 3'd0, 1);

        // Randomised traffic with occasional clears.
        for (int n = 0; n < 60; n++)
            cyc(0, 1'($urandom), 3'($urandom), 8'($urandom), 1'($urandom), 3'($urandom),
                8'($urandom), 3'($urandom), ($urandom_range(0, 9) == 0));

        // Long race run: counter saturation when built, still tied low otherwise.
        for (int n = 0; n < 300; n++)
            cyc(0, 1, 3'(n), 8'(n), 1, 3'(n), 8'(~n), 3'(n), 0);

        // Reset during a race: nothing written, everything cleared.
        cyc(0, 1, 3'd7, 8'h77, 0, 0, 8'h00, 3'd7, 0);
        cyc(1, 1, 3'd7, 8'h99, 1, 3'd7, 8'h66, 3'd7, 0);
        cyc(0, 0, 0, 8'h00, 0, 0, 8'h00, 3'd7, 0);
        cyc(0, 0, 0, 8'h00, 0, 0, 8'h00, 3'd7, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/hedios_register_bank.md
Name: hedios_register_bank

Overview:
Parametrised bank of COUNT registers, each DEPTH bits wide. Two write ports: the HEDIOS engine port and the user port. A registered read port. Per-register race (same-cycle, same-address write) detection with a pulse output and sticky flags. This block is the multi-register successor of the single dual-writer register and sits between the HEDIOS core and user logic.

Parameters:
DEPTH, 8, data width of each register in bits
COUNT, 8, number of registers (>=2)
ADDR_W, 3, address width; must satisfy 2**ADDR_W >= COUNT
USER_PRIORITY, 1, on a race: 1 = user data wins, 0 = hedios data wins

Ports:
clk  input  1  clock; all logic is on the rising edge
rst  input  1  synchronous reset, active-high
hedios_addr  input  ADDR_W  HEDIOS write address
hedios_in  input  DEPTH  HEDIOS write data
hedios_we  input  1  HEDIOS write enable
user_addr  input  ADDR_W  user write address
user_in  input  DEPTH  user write data
user_we  input  1  user write enable
rd_addr  input  ADDR_W  read address
rd_data  output  DEPTH  registered read data
race_condition  output  1  one-cycle pulse: a race occurred at the previous edge
race_addr  output  ADDR_W  address of the last race; holds until the next race
race_sticky  output  COUNT  per-register sticky race flags
race_clear  input  1  clears all race_sticky bits
race_count  output  8  saturating race counter (only with the optional feature)

Behaviour:
- Reset (rst=1 at an edge): all registers go to 0. rd_data, race_condition, race_addr, race_sticky and race_count all go to 0. Reset overrides every other input in that cycle.
- Write decode per edge:
  - Only hedios_we=1: reg[hedios_addr] <= hedios_in.
  - Only user_we=1: reg[user_addr] <= user_in.
  - Both enables, different addresses: both writes happen; this is not a race.
  - Both enables, same address: this is a race. The winner is selected by USER_PRIORITY and the loser's data is discarded.
- Out-of-range address (>= COUNT): the write is ignored, with no race even if both ports hit it. A read at that address returns 0.
- Read: rd_data at edge N+1 reflects rd_addr sampled at edge N. The read is read-before-write, so a same-edge write to rd_addr is not visible until the following read.
- Race reporting: on the edge where a race is detected:
  - race_condition <= 1; otherwise it is 0 at every edge.
  - race_addr <= the conflicting address.
  - race_sticky[addr] <= 1.
- race_clear=1 zeroes all sticky bits at the edge. If a race occurs in the same cycle, its bit is set: set wins over clear for that bit only.
- Registers hold their value when no write targets them.
- Latency: write data is visible on rd_data 2 edges after the write cycle when rd_addr is held.

Optional Feature:
HEDIOS_REG_RACE_COUNTER_EN
- Defined: race_count increments by 1 on each race edge and saturates at 255. race_clear resets it to 0; if a race occurs in the same cycle, the count becomes 1. Reset sets it to 0.
- Undefined: no counter logic is built and race_count is tied to 0.

Test Plan:
- Reset then read all addresses: rst=1 for 2 cycles, sweep rd_addr 0..7 -> rd_data=0 every cycle, race_sticky=0, race_condition=0.
- Single-port writes: hedios writes 0xA5 to addr 2, user writes 0x3C to addr 5 in separate cycles -> reads return 0xA5 and 0x3C, race_condition stays 0.
- Dual write, different addresses in one cycle: hedios 0x11 to addr 1, user 0x22 to addr 6 -> both stored, no race flags.
- Race with USER_PRIORITY=1: hedios 0xAA and user 0x55 both to addr 3 -> reg[3]=0x55, race_condition pulses for exactly one cycle, race_addr=3, race_sticky=8'b0000_1000. Repeat with USER_PRIORITY=0 -> reg[3]=0xAA.
- Clear vs set collision: sticky bit 3 already set; in one cycle assert race_clear and a race on addr 4 -> race_sticky=8'b0001_0000; with the feature built, race_count=1.
- Saturation and reset mid-operation (feature built): 300 consecutive races -> race_count=255. Assert rst during a race cycle -> all outputs 0 next cycle and the register is not written.
